// File: rtl/sq_recon_pkg.sv
// Shared constants for the square reconstructor and the sqrt wrapper that pairs with it.
// Keeping the width and state encoding here keeps both sides of the round trip in step.
package sq_recon_pkg;

  localparam int SQ_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_ADD  = 2'd2;

endpackage

// File: rtl/sq_recon.sv
// Iterative square reconstructor: rad = root*root + rem, MSB-first shift-add, one root bit
// per clock, plus a flag for (root, rem) pairs that no exact integer square root could give.
module sq_recon
  import sq_recon_pkg::*;
#(
  parameter int W     = SQ_W,
  parameter int CNT_W = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   root,
  input  logic [W:0]     rem,
  output logic           busy,
  output logic           valid,
  output logic [2*W-1:0] rad,
  output logic           err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     rop;
  logic [W-1:0]     mcand;
  logic [W:0]       rrem;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   acc_d;
  logic [2*W:0]     sum;
  logic             err_q;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; a start strobe restarts from any state.
  // NOTE: state_d gets a default first so no path leaves it unassigned (no inferred latch).
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: state_d = ST_IDLE;
      ST_MUL:  if (cnt == LAST_CNT) state_d = ST_ADD;
      ST_ADD:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d = ST_MUL;
    end
  end

  // Output logic.
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // rop is the multiplier, consumed MSB first; mcand keeps the unshifted root as multiplicand.
  always_comb begin
    acc_d = {acc[2*W-2:0], 1'b0};
    if (rop[W-1]) begin
      acc_d = acc_d + {{W{1'b0}}, mcand};
    end
    sum = {1'b0, acc} + {{W{1'b0}}, rrem};
  end

  // Datapath registers. Everything is a flop, so all of it is cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rop   <= '0;
      mcand <= '0;
      rrem  <= '0;
      acc   <= '0;
      err_q <= 1'b0;
      rad   <= '0;
      err   <= 1'b0;
      valid <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      rop   <= root;
      mcand <= root;
      rrem  <= rem;
      acc   <= '0;
      err_q <= (rem > {root, 1'b0});
      valid <= 1'b0;
    end else begin
      case (state)
        ST_MUL: begin
          acc <= acc_d;
          rop <= {rop[W-2:0], 1'b0};
          cnt <= cnt + CNT_W'(1);
        end
        ST_ADD: begin
          // Carry-out can only occur when rem already exceeds 2*root.
          rad   <= sum[2*W-1:0];
          err   <= err_q | sum[2*W];
          valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sq_recon.sv
// Self-checking bench for sq_recon: a cycle-level reference model checked every clock,
// plus directed operations whose results are pinned with hand-computed literals.
module tb_sq_recon;
  import sq_recon_pkg::*;

  localparam int W = SQ_W;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   root  = '0;
  logic [W:0]     rem   = '0;
  logic           busy;
  logic           valid;
  logic [2*W-1:0] rad;
  logic           err;

  int checks   = 0;
  int failures = 0;

  sq_recon dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .root  (root),
    .rem   (rem),
    .busy  (busy),
    .valid (valid),
    .rad   (rad),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_rad(input logic [W-1:0] r, input logic [W:0] m);
    logic [63:0] r64;
    r64 = 64'(r);
    return r64 * r64 + 64'(m);  // wraps modulo 2^64
  endfunction

  function automatic logic ref_err(input logic [W-1:0] r, input logic [W:0] m);
    return 64'(m) > 64'(r) * 64'd2;
  endfunction

  logic        m_busy     = 1'b0;
  logic        m_valid    = 1'b0;
  logic        m_err      = 1'b0;
  logic [63:0] m_rad      = '0;
  logic [63:0] m_pend_rad = '0;
  logic        m_pend_err = 1'b0;
  int          m_cnt      = 0;

  // Result appears W+1 clocks after the most recent start edge; outputs hold otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      m_rad   <= '0;
      m_cnt   <= 0;
    end else if (start) begin
      m_busy     <= 1'b1;
      m_valid    <= 1'b0;
      m_cnt      <= W + 1;
      m_pend_rad <= ref_rad(root, rem);
      m_pend_err <= ref_err(root, rem);
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_rad   <= m_pend_rad;
        m_err   <= m_pend_err;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    check("cyc_busy",  64'(busy),  64'(m_busy));
    check("cyc_valid", 64'(valid), 64'(m_valid));
    check("cyc_rad",   rad,        m_rad);
    check("cyc_err",   64'(err),   64'(m_err));
  end

  // ---------------- stimulus helpers ----------------
  // Called on a falling edge; issues a one-cycle start and returns on the next falling edge.
  task automatic launch(input logic [W-1:0] r, input logic [W:0] m);
    root  = r;
    rem   = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the falling edge right after the start edge; waits for valid with a bound.
  task automatic await_result(input string name, input logic [63:0] exp_rad, input logic exp_err);
    int lat  = 0;
    int bcnt = 0;
    while (!valid && lat < W + 8) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    check({name, "_valid_seen"}, 64'(valid), 64'd1);
    check({name, "_latency"},    64'(lat),   64'(W + 1));
    check({name, "_busy_cyc"},   64'(bcnt),  64'(W + 1));
    check({name, "_rad"},        rad,        exp_rad);
    check({name, "_err"},        64'(err),   64'(exp_err));
  endtask

  function automatic logic [63:0] isqrt(input logic [63:0] x);
    logic [63:0] r;
    logic [63:0] t;
    r = '0;
    for (int b = W - 1; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] x;
    logic [63:0] r;
    int          rises;
    int          first_lat;
    logic        prev_valid;
    int          vseen;

    repeat (3) @(negedge clk);
    check("reset_busy",  64'(busy),  64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_rad",   rad,        64'd0);
    check("reset_err",   64'(err),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. zero operands
    launch('0, '0);
    await_result("zero", 64'd0, 1'b0);

    // 2. basic products
    launch(32'd5, 33'd3);
    await_result("r5m3", 64'd28, 1'b0);
    launch(32'd65535, 33'd0);
    await_result("r65535", 64'd4294836225, 1'b0);

    // 3. maximum legal pair, then one past it wraps
    launch(32'hFFFF_FFFF, 33'h1_FFFF_FFFE);
    await_result("max_legal", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    launch(32'hFFFF_FFFF, 33'h1_FFFF_FFFF);
    await_result("max_wrap", 64'd0, 1'b1);

    // 4. err boundary around rem == 2*root
    launch(32'd3, 33'd7);
    await_result("r3m7", 64'd16, 1'b1);
    launch(32'd3, 33'd6);
    await_result("r3m6", 64'd15, 1'b0);
    launch(32'd0, 33'd5);
    await_result("r0m5", 64'd5, 1'b1);
    launch(32'd1, 33'd2);
    await_result("r1m2", 64'd3, 1'b0);

    // back-to-back: start in the cycle valid rises
    launch(32'd12, 33'd4);
    await_result("b2b_a", 64'd148, 1'b0);
    launch(32'd1, 33'd3);
    check("b2b_valid_drop", 64'(valid), 64'd0);
    await_result("b2b_b", 64'd4, 1'b1);

    // start held for three cycles: only the last operands count
    root = 32'd100; rem = '0; start = 1'b1;
    @(negedge clk);
    root = 32'd200;
    @(negedge clk);
    root = 32'd300;
    @(negedge clk);
    start = 1'b0;
    await_result("held", 64'd90000, 1'b0);

    // 5. restart mid-MUL: exactly one valid, timed from the second start
    launch(32'd10, 33'd0);
    repeat (11) @(negedge clk);
    launch(32'd7, 33'd1);
    rises      = 0;
    first_lat  = -1;
    prev_valid = valid;
    for (int i = 0; i < W + 10; i++) begin
      if (valid && !prev_valid) begin
        rises++;
        if (first_lat < 0) first_lat = i;
      end
      prev_valid = valid;
      @(negedge clk);
    end
    check("abort_rises",   64'(rises),     64'd1);
    check("abort_latency", 64'(first_lat), 64'(W + 1));
    check("abort_rad",     rad,            64'd50);
    check("abort_err",     64'(err),       64'd0);

    // asynchronous reset mid-MUL
    launch(32'd9, 33'd2);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",  64'(busy),  64'd0);
    check("arst_valid", 64'(valid), 64'd0);
    check("arst_rad",   rad,        64'd0);
    check("arst_err",   64'(err),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vseen = 0;
    for (int i = 0; i < W + 10; i++) begin
      @(negedge clk);
      if (valid) vseen++;
    end
    check("arst_no_valid", 64'(vseen), 64'd0);

    // 6. round trip through an integer square root
    for (int n = 0; n < 1000; n++) begin
      if (n == 0)      x = 64'd0;
      else if (n == 1) x = 64'hFFFF_FFFF_FFFF_FFFF;
      else             x = {$urandom(), $urandom()};
      r = isqrt(x);
      launch(r[W-1:0], (W + 1)'(x - r * r));
      await_result("roundtrip", x, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
